// File: rtl/seg7_anim_scheduler.sv
// rtl/seg7_anim_scheduler.sv - animation index / speed compare sequencer with auto-play FSM
// Button edges become one-shot commands; auto-play advances the index every AUTO_LOOPS digit wraps.
module seg7_anim_scheduler #(
  parameter int STATE_BITS  = 6,
  parameter int CMP_W       = 25,
  parameter int CMP_DEFAULT = 10_000_000,
  parameter int CMP_MIN     = 1_000_000,
  parameter int CMP_MAX     = 19_000_000,
  parameter int CMP_STEP    = 1_000_000,
  parameter int AUTO_LOOPS  = 4,
  parameter int HOLD_WRAPS  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_btn_next,
  input  logic                  i_btn_prev,
  input  logic                  i_btn_faster,
  input  logic                  i_btn_slower,
  input  logic                  i_auto_en,
  input  logic                  i_digit_wrap,
  output logic [STATE_BITS-1:0] o_animation,
  output logic [CMP_W-1:0]      o_compare,
  output logic                  o_anim_changed,
  output logic                  o_auto_active
);

  localparam int LOOP_W = $clog2(AUTO_LOOPS + 1);
  localparam int HOLD_W = $clog2(HOLD_WRAPS + 1);

  typedef enum logic [1:0] {ST_MANUAL, ST_AUTO, ST_HOLD} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LOOP_W-1:0]     r_loop_cnt;
  logic [LOOP_W-1:0]     w_loop_nxt;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic [HOLD_W-1:0]     w_hold_nxt;
  logic                  r_next_q;
  logic                  r_prev_q;
  logic                  r_faster_q;
  logic                  r_slower_q;
  logic [STATE_BITS-1:0] r_animation;
  logic [CMP_W-1:0]      r_compare;
  logic                  r_anim_changed;
  logic                  r_auto_active;

  logic                  w_req_next;
  logic                  w_req_prev;
  logic                  w_req_faster;
  logic                  w_req_slower;
  logic                  w_manual;
  logic                  w_auto_adv;
  logic [STATE_BITS-1:0] w_anim_nxt;
  logic [CMP_W-1:0]      w_cmp_nxt;
  logic [CMP_W:0]        w_cmp_up;

  assign w_req_next   = i_btn_next   & ~r_next_q;
  assign w_req_prev   = i_btn_prev   & ~r_prev_q;
  assign w_req_faster = i_btn_faster & ~r_faster_q;
  assign w_req_slower = i_btn_slower & ~r_slower_q;
  // Simultaneous next+prev cancels out and is not treated as a manual change.
  assign w_manual     = w_req_next ^ w_req_prev;

  always_comb begin
    w_state_nxt = r_state;
    w_loop_nxt  = r_loop_cnt;
    w_hold_nxt  = r_hold_cnt;
    w_auto_adv  = 1'b0;
    if (!i_auto_en) begin
      w_state_nxt = ST_MANUAL;
      w_loop_nxt  = '0;
      w_hold_nxt  = '0;
    end else begin
      case (r_state)
        ST_MANUAL: begin
          w_state_nxt = ST_AUTO;
          w_loop_nxt  = '0;
          w_hold_nxt  = '0;
        end
        ST_AUTO: begin
          if (w_manual) begin
            w_state_nxt = ST_HOLD;
            w_loop_nxt  = '0;
            w_hold_nxt  = '0;
          end else if (i_digit_wrap) begin
            if (r_loop_cnt == LOOP_W'(AUTO_LOOPS - 1)) begin
              w_auto_adv = 1'b1;
              w_loop_nxt = '0;
            end else begin
              w_loop_nxt = r_loop_cnt + LOOP_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (w_manual) begin
            w_hold_nxt = '0;
          end else if (i_digit_wrap) begin
            if (r_hold_cnt == HOLD_W'(HOLD_WRAPS - 1)) begin
              w_state_nxt = ST_AUTO;
              w_loop_nxt  = '0;
              w_hold_nxt  = '0;
            end else begin
              w_hold_nxt = r_hold_cnt + HOLD_W'(1);
            end
          end
        end
        default: begin
          w_state_nxt = ST_MANUAL;
          w_loop_nxt  = '0;
          w_hold_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_anim_nxt = r_animation;
    if (w_manual) begin
      w_anim_nxt = w_req_next ? r_animation + STATE_BITS'(1) : r_animation - STATE_BITS'(1);
    end else if (w_auto_adv) begin
      w_anim_nxt = r_animation + STATE_BITS'(1);
    end
  end

  // One extra bit on the upward path so the clamp sees the true sum.
  assign w_cmp_up = {1'b0, r_compare} + (CMP_W + 1)'(CMP_STEP);

  always_comb begin
    w_cmp_nxt = r_compare;
    if (w_req_faster && !w_req_slower) begin
      if (r_compare < CMP_W'(CMP_MIN + CMP_STEP)) begin
        w_cmp_nxt = CMP_W'(CMP_MIN);
      end else begin
        w_cmp_nxt = r_compare - CMP_W'(CMP_STEP);
      end
    end else if (w_req_slower && !w_req_faster) begin
      if (w_cmp_up > (CMP_W + 1)'(CMP_MAX)) begin
        w_cmp_nxt = CMP_W'(CMP_MAX);
      end else begin
        w_cmp_nxt = w_cmp_up[CMP_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_MANUAL;
      r_loop_cnt     <= '0;
      r_hold_cnt     <= '0;
      r_next_q       <= 1'b0;
      r_prev_q       <= 1'b0;
      r_faster_q     <= 1'b0;
      r_slower_q     <= 1'b0;
      r_animation    <= '0;
      r_compare      <= CMP_W'(CMP_DEFAULT);
      r_anim_changed <= 1'b0;
      r_auto_active  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_loop_cnt     <= w_loop_nxt;
      r_hold_cnt     <= w_hold_nxt;
      r_next_q       <= i_btn_next;
      r_prev_q       <= i_btn_prev;
      r_faster_q     <= i_btn_faster;
      r_slower_q     <= i_btn_slower;
      r_animation    <= w_anim_nxt;
      r_compare      <= w_cmp_nxt;
      r_anim_changed <= w_manual | w_auto_adv;
      r_auto_active  <= (w_state_nxt == ST_AUTO);
    end
  end

  assign o_animation    = r_animation;
  assign o_compare      = r_compare;
  assign o_anim_changed = r_anim_changed;
  assign o_auto_active  = r_auto_active;

endmodule
